dmem_lsu_ram: RTL

Parametrised single-port data memory for the pipeline's MEM stage.
- Request/response handshake; accepts at most one request per cycle.
- Byte addressing; internally generated byte enables for byte/half/word (and double when DATA_WIDTH=64) accesses.
- Sign/zero-extended load formatting, misalignment error reporting, configurable pipelined read latency.
- Optional post-reset clear sequence.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_lsu_ram_if.sv | 32 +++
 rtl/dmem_load_fmt.sv | 39 +++
 rtl/dmem_lsu_ram.sv | 122 ++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the MEM-stage data RAM.
// Access sizes, FSM states, lane enables and alignment checks.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic logic [7:0] byte_en(
    input logic [1:0] size,
    input logic [2:0] offset,
    input int         nb
  );
    logic [7:0] m;
    logic [7:0] lim;
    m   = 8'hFF >> (4'd8 - (4'd1 << size));
    lim = 8'hFF >> (4'd8 - 4'(nb));
    return (m << offset) & lim;
  endfunction

  function automatic logic is_misaligned(
    input logic [2:0] addr,
    input logic [1:0] size
  );
    return |(addr & ~(3'h7 << size));
  endfunction

endpackage

// File: rtl/dmem_lsu_ram_if.sv
// Request/response bundle between the MEM stage and the data RAM.
// Master issues requests; slave answers in order.
interface dmem_lsu_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  init_done;

  modport master (
    output req_valid, req_we, req_addr,
    output req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, init_done
  );
endinterface

// File: rtl/dmem_load_fmt.sv
// Load formatter: lane select plus sign/zero extension.
// Purely combinational; feeds the response pipeline.
module dmem_load_fmt
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFFW       = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [OFFW-1:0]       off,
  input  logic [1:0]            size,
  input  logic                  uns,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] sh;

  assign sh = word >> {off, 3'b000};

  always_comb begin
    rdata = sh;
    unique case (size)
      SZ_B: begin
        if (uns) rdata = DATA_WIDTH'(sh[7:0]);
        else     rdata = DATA_WIDTH'($signed(sh[7:0]));
      end
      SZ_H: begin
        if (uns) rdata = DATA_WIDTH'(sh[15:0]);
        else     rdata = DATA_WIDTH'($signed(sh[15:0]));
      end
      SZ_W: begin
        if (uns) rdata = DATA_WIDTH'(sh[31:0]);
        else     rdata = DATA_WIDTH'($signed(sh[31:0]));
      end
      default: rdata = sh;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ram.sv
// Single-port data RAM for the MEM stage with byte enables,
// load formatting, error reporting and a fixed-latency response pipe.
module dmem_lsu_ram
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic           clk,
  input logic           rst_n,
  dmem_lsu_ram_if.slave bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int WAW   = ADDR_WIDTH - OFFW;
  localparam int DEPTH = 1 << WAW;

  state_t state_q, state_d;
  logic   rdy, clr_we;

  logic [WAW-1:0]        clr_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc, err, wr;
  logic [OFFW-1:0]       off;
  logic [WAW-1:0]        widx;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wsh, rword, fmt;

  logic [RD_LATENCY-1:0] v_q, e_q;
  logic [DATA_WIDTH-1:0] d_q [RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: begin
        if (CLEAR_ON_RESET == 0 || clr_q == WAW'(DEPTH - 1))
          state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    rdy    = 1'b0;
    clr_we = 1'b0;
    unique case (state_q)
      ST_INIT:  clr_we = (CLEAR_ON_RESET != 0);
      ST_READY: rdy    = 1'b1;
      default:  rdy    = 1'b0;
    endcase
  end

  assign bus.req_ready = rdy;
  assign bus.init_done = rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      clr_q <= '0;
    else if (clr_we) clr_q <= clr_q + 1'b1;
  end

  assign acc  = bus.req_valid & rdy;
  assign off  = bus.req_addr[OFFW-1:0];
  assign widx = bus.req_addr[ADDR_WIDTH-1:OFFW];
  assign err  = is_misaligned(bus.req_addr[2:0], bus.req_size)
              | (bus.req_size == SZ_D && NB == 4);
  assign wr   = acc & bus.req_we & ~err;
  assign be   = NB'(byte_en(bus.req_size, 3'(off), NB));
  assign wsh  = bus.req_wdata << {off, 3'b000};
  assign rword = mem[widx];

  // Storage carries no reset; the clear walk zeroes it instead.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_q] <= '0;
    end else if (wr) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wsh[8*i +: 8];
    end
  end

  dmem_load_fmt #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fmt (
    .word  (rword),
    .off   (off),
    .size  (bus.req_size),
    .uns   (bus.req_unsigned),
    .rdata (fmt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      e_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= acc;
      e_q[0] <= acc & err;
      d_q[0] <= (acc & ~err & ~bus.req_we) ? fmt : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        e_q[i] <= e_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign bus.resp_valid = v_q[RD_LATENCY-1];
  assign bus.resp_err   = e_q[RD_LATENCY-1];
  assign bus.resp_rdata = d_q[RD_LATENCY-1];

endmodule
